instr_fetch: RTL and testbench

Instruction fetch stage sitting directly downstream of the PC counter. Accepts the next fetch address and issues one request at a time to instruction memory over a grant/response handshake. Buffers returned words with their PC in a small FIFO for the decoder. Discards buffered and in-flight fetches on a branch/jump redirect.

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/instr_fetch_if.sv | 28 ++
 rtl/instr_fetch_fifo.sv | 82 ++++++++
 rtl/instr_fetch.sv | 161 ++++++++++++++++
 tb/tb_instr_fetch.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM state
// encoding and the instruction alignment mask/check.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_WAIT  = 2'd2,
        FETCH_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

    // Instructions are word aligned; any set low address bit is a fault.
    function automatic logic is_misaligned(input logic [1:0] pc_lsbs);
        return (pc_lsbs & INSTR_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/response bus: the fetch stage is the master,
// the instruction memory is the slave.
interface instr_fetch_if #(
    parameter int PC_WIDTH  = 12,
    parameter int OPD_WIDTH = 32
);
    logic                 imem_req;
    logic [PC_WIDTH-1:0]  imem_addr;
    logic                 imem_gnt;
    logic                 imem_rvalid;
    logic [OPD_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_fifo.sv
// Small power-of-two FIFO holding {pc, instruction} entries for the decoder.
// A synchronous clear empties it and takes priority over push and pop.
module instr_fetch_fifo #(
    parameter int  WIDTH = 44,
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             valid
);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_pop_s  = pop && (count_q != '0);
        do_push_s = push && ((count_q != FULL_CNT) || do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign valid = (count_q != '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request, returned words
// buffered with their PC. Optional FETCH_MISALIGN_CHECK_EN blocks unaligned fetches.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int OPD_WIDTH  = 32,
    parameter int PC_WIDTH   = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PC_WIDTH-1:0]  pc_in,
    input  logic                 pc_valid,
    output logic                 pc_ready,
    input  logic                 flush,
    instr_fetch_if.master        imem,
    output logic                 instr_valid,
    output logic [OPD_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]  instr_pc,
    input  logic                 instr_ready,
    output logic                 misalign_fault
);
    localparam int               CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int               ENT_W    = PC_WIDTH + OPD_WIDTH;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    fetch_state_e        state_q, state_d;
    logic                req_q, req_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic                push_s;
    logic [CNT_W-1:0]    count_s;
    logic [ENT_W-1:0]    head_s;
    logic                fifo_valid_s;
    logic                accept_s;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic fault_set_s;

    assign pc_ready = (state_q == FETCH_IDLE) && (count_s < FULL_CNT) && !flush && !fault_q;
`else
    assign pc_ready = (state_q == FETCH_IDLE) && (count_s < FULL_CNT) && !flush;
`endif

    assign accept_s = pc_valid && pc_ready;

    // Fetch sequencing: issue, wait for response, or drain a killed response.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        push_s  = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_set_s = 1'b0;
`endif
        case (state_q)
            FETCH_IDLE: begin
                if (accept_s) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (is_misaligned(pc_in[1:0])) begin
                        fault_set_s = 1'b1;
                    end else begin
                        state_d = FETCH_REQ;
                        req_d   = 1'b1;
                        addr_d  = pc_in;
                    end
`else
                    state_d = FETCH_REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_in;
`endif
                end else begin
                    state_d = FETCH_IDLE;
                end
            end
            FETCH_REQ: begin
                // A grant commits memory to a response, so a flush then must drain it.
                if (imem.imem_gnt) begin
                    req_d   = 1'b0;
                    state_d = flush ? FETCH_DRAIN : FETCH_WAIT;
                end else if (flush) begin
                    req_d   = 1'b0;
                    state_d = FETCH_IDLE;
                end else begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_WAIT: begin
                if (imem.imem_rvalid) begin
                    push_s  = !flush;
                    state_d = FETCH_IDLE;
                end else if (flush) begin
                    state_d = FETCH_DRAIN;
                end else begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_DRAIN: begin
                if (imem.imem_rvalid) begin
                    state_d = FETCH_IDLE;
                end else begin
                    state_d = FETCH_DRAIN;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
                req_d   = 1'b0;
            end
        endcase
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_d = flush ? 1'b0 : (fault_q || fault_set_s);
`endif
    end

    // FSM state and registered request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

    instr_fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push_s),
        .wdata ({addr_q, imem.imem_rdata}),
        .pop   (fifo_valid_s && instr_ready),
        .rdata (head_s),
        .count (count_s),
        .valid (fifo_valid_s)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign instr_valid    = fifo_valid_s;
    assign instr_pc       = head_s[ENT_W-1:OPD_WIDTH];
    assign instr          = head_s[OPD_WIDTH-1:0];

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign_fault = fault_q;
`else
    assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_instr_fetch;
    localparam int OPD_WIDTH  = 32;
    localparam int PC_WIDTH   = 12;
    localparam int FIFO_DEPTH = 2;
    localparam int ENT_W      = OPD_WIDTH + PC_WIDTH;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [PC_WIDTH-1:0]  pc_in = '0;
    logic                 pc_valid = 1'b0;
    logic                 pc_ready;
    logic                 flush = 1'b0;
    logic                 instr_valid;
    logic [OPD_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]  instr_pc;
    logic                 instr_ready = 1'b0;
    logic                 misalign_fault;

    instr_fetch_if #(.PC_WIDTH(PC_WIDTH), .OPD_WIDTH(OPD_WIDTH)) imem_if ();

    instr_fetch #(
        .OPD_WIDTH  (OPD_WIDTH),
        .PC_WIDTH   (PC_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .flush          (flush),
        .imem           (imem_if),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .misalign_fault (misalign_fault)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [ENT_W-1:0]    m_q[$];
    bit                  m_busy, m_granted, m_killed, m_fault;
    logic [PC_WIDTH-1:0] m_addr;
    bit                  chk_en = 1'b0;

    function automatic bit m_pc_ready();
        return !m_busy && (m_q.size() < FIFO_DEPTH) && !flush && !m_fault;
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            m_q.delete();
            m_busy = 0; m_granted = 0; m_killed = 0; m_fault = 0; m_addr = '0;
        end else begin
            acc = pc_valid && m_pc_ready();
            if (m_q.size() > 0 && instr_ready) void'(m_q.pop_front());
            if (imem_if.imem_rvalid && m_granted) begin
                if (!m_killed && !flush) m_q.push_back({m_addr, imem_if.imem_rdata});
                m_busy = 0; m_granted = 0;
            end else if (m_busy && !m_granted && imem_if.imem_gnt) begin
                m_granted = 1; m_killed = flush;
            end else if (m_busy && !m_granted && flush) begin
                m_busy = 0;
            end else if (m_granted && flush) begin
                m_killed = 1;
            end
            if (flush) begin
                m_q.delete();
                m_fault = 0;
            end
            if (acc) begin
                if (MIS_EN && (pc_in[1:0] != 2'b00)) m_fault = 1;
                else begin m_busy = 1; m_addr = pc_in; end
            end
        end
    end

    // Compare DUT outputs with the model every cycle
    always @(negedge clk) begin
        logic [ENT_W-1:0] ent;
        if (chk_en && !rst) begin
            chk("instr_valid", 64'(instr_valid), 64'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                ent = m_q[0];
                chk("instr_pc", 64'(instr_pc), 64'(ent[ENT_W-1:OPD_WIDTH]));
                chk("instr", 64'(instr), 64'(ent[OPD_WIDTH-1:0]));
            end
            chk("pc_ready", 64'(pc_ready), 64'(m_pc_ready()));
            chk("imem_req", 64'(imem_if.imem_req), 64'(m_busy && !m_granted));
            if (m_busy && !m_granted) chk("imem_addr", 64'(imem_if.imem_addr), 64'(m_addr));
            chk("misalign_fault", 64'(misalign_fault), 64'(m_fault));
        end
    end

    // ---------------- instruction memory ----------------
    int                  gnt_pct = 100, dly_min = 1, dly_max = 1, resp_cnt = -1;
    bit                  fixed_data = 1, dead_data = 0, stray_en = 0;
    logic [PC_WIDTH-1:0] resp_addr = '0;

    initial begin
        bit                  g;
        logic [PC_WIDTH-1:0] ga;
        imem_if.imem_gnt = 1'b0; imem_if.imem_rvalid = 1'b0; imem_if.imem_rdata = '0;
        forever begin
            @(posedge clk);
            g  = imem_if.imem_req && imem_if.imem_gnt;
            ga = imem_if.imem_addr;
            #1;
            if (g) begin resp_cnt = $urandom_range(dly_max, dly_min); resp_addr = ga; end
            imem_if.imem_rvalid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    imem_if.imem_rvalid = 1'b1;
                    imem_if.imem_rdata  = dead_data ? 32'hDEAD_BEEF :
                                          fixed_data ? {20'h12345, resp_addr} : $urandom;
                    resp_cnt = -1;
                end
            end else if (stray_en && !m_busy && ($urandom_range(15, 0) == 0)) begin
                imem_if.imem_rvalid = 1'b1;
                imem_if.imem_rdata  = $urandom;
            end
            imem_if.imem_gnt = imem_if.imem_req && ($urandom_range(99, 0) < gnt_pct);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_fifo(input logic [PC_WIDTH-1:0] base);
        bit acc;
        instr_ready = 1'b0; pc_valid = 1'b1; pc_in = base;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            acc = pc_valid && pc_ready;
            #1;
            if (acc) pc_in = pc_in + 12'd4;
        end
    endtask

    task automatic check_reset_values(input string p);
        chk({p, "_valid"}, 64'(instr_valid), 64'd0);
        chk({p, "_req"}, 64'(imem_if.imem_req), 64'd0);
        chk({p, "_addr"}, 64'(imem_if.imem_addr), 64'd0);
        chk({p, "_instr"}, 64'(instr), 64'd0);
        chk({p, "_pc"}, 64'(instr_pc), 64'd0);
        chk({p, "_fault"}, 64'(misalign_fault), 64'd0);
        chk({p, "_pc_ready"}, 64'(pc_ready), 64'd1);
    endtask

    initial begin
        bit r;
        repeat (3) step();
        rst = 1'b0; chk_en = 1'b1;
        @(negedge clk);
        check_reset_values("rst");

        // Basic fetch, immediate grant, response one cycle later
        for (int i = 0; i < 3; i++) begin
            step(); pc_in = 12'(i * 4); pc_valid = 1'b1; instr_ready = 1'b1;
            @(negedge clk); chk("bf_pc_ready", 64'(pc_ready), 64'd1);
            step(); pc_valid = 1'b0;
            @(negedge clk); chk("bf_req", 64'(imem_if.imem_req), 64'd1);
            chk("bf_addr", 64'(imem_if.imem_addr), 64'(i * 4));
            step();
            @(negedge clk); chk("bf_req_low", 64'(imem_if.imem_req), 64'd0);
            chk("bf_early", 64'(instr_valid), 64'd0);
            step();
            @(negedge clk); chk("bf_valid", 64'(instr_valid), 64'd1);
            chk("bf_pc", 64'(instr_pc), 64'(i * 4));
            chk("bf_instr", 64'(instr), 64'({20'h12345, 12'(i * 4)}));
        end

        // Backpressure: two buffered, third held off until a pop
        step();
        fill_fifo(12'h010);
        @(negedge clk); chk("bp_pc_ready", 64'(pc_ready), 64'd0);
        chk("bp_valid", 64'(instr_valid), 64'd1);
        chk("bp_head", 64'(instr_pc), 64'h010);
        step(); instr_ready = 1'b1;
        step(); instr_ready = 1'b0;
        @(negedge clk); chk("bp_pop_ready", 64'(pc_ready), 64'd1);
        chk("bp_head2", 64'(instr_pc), 64'h014);
        step(); pc_valid = 1'b0; instr_ready = 1'b1;
        repeat (8) step();

        // Flush one cycle after grant; stale 0xDEADBEEF must vanish
        dly_min = 3; dly_max = 3; dead_data = 1;
        pc_in = 12'h0F0; pc_valid = 1'b1;
        step(); pc_valid = 1'b0;
        step(); flush = 1'b1;
        step(); flush = 1'b0;
        @(negedge clk); chk("fw_drain_ready", 64'(pc_ready), 64'd0);
        step(); step();
        @(negedge clk); chk("fw_valid", 64'(instr_valid), 64'd0);
        chk("fw_idle_ready", 64'(pc_ready), 64'd1);
        dead_data = 0; dly_min = 1; dly_max = 1;
        step(); pc_in = 12'h100; pc_valid = 1'b1;
        step(); pc_valid = 1'b0;
        step(); step();
        @(negedge clk); chk("fw_next_valid", 64'(instr_valid), 64'd1);
        chk("fw_next_pc", 64'(instr_pc), 64'h100);

        // Flush coincident with grant
        step(); dead_data = 1; dly_min = 2; dly_max = 2;
        pc_in = 12'h200; pc_valid = 1'b1;
        step(); pc_valid = 1'b0; flush = 1'b1;
        step(); flush = 1'b0;
        @(negedge clk); chk("fg_ready", 64'(pc_ready), 64'd0);
        chk("fg_req", 64'(imem_if.imem_req), 64'd0);
        step(); step();
        @(negedge clk); chk("fg_valid", 64'(instr_valid), 64'd0);
        chk("fg_idle_ready", 64'(pc_ready), 64'd1);
        dead_data = 0; dly_min = 1; dly_max = 1;

        // Flush with FIFO full
        step();
        fill_fifo(12'h300);
        @(negedge clk); chk("ff_full_valid", 64'(instr_valid), 64'd1);
        chk("ff_full_ready", 64'(pc_ready), 64'd0);
        step(); pc_valid = 1'b0; flush = 1'b1;
        step(); flush = 1'b0;
        @(negedge clk); chk("ff_valid", 64'(instr_valid), 64'd0);

        // Reset while waiting, response lands afterwards
        dly_min = 3; dly_max = 3;
        step(); pc_in = 12'h400; pc_valid = 1'b1;
        step(); pc_valid = 1'b0;
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        step(); step();
        @(negedge clk); check_reset_values("rs");

        // Misaligned fetch
        step(); pc_in = 12'h002; pc_valid = 1'b1; instr_ready = 1'b1;
        step(); pc_valid = 1'b0;
        @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("ms_fault", 64'(misalign_fault), 64'd1);
        chk("ms_req", 64'(imem_if.imem_req), 64'd0);
        chk("ms_ready", 64'(pc_ready), 64'd0);
        step();
        @(negedge clk); chk("ms_sticky", 64'(misalign_fault), 64'd1);
        step(); flush = 1'b1;
        step(); flush = 1'b0;
        @(negedge clk); chk("ms_cleared", 64'(misalign_fault), 64'd0);
        chk("ms_ready_back", 64'(pc_ready), 64'd1);
`else
        chk("ua_req", 64'(imem_if.imem_req), 64'd1);
        chk("ua_addr", 64'(imem_if.imem_addr), 64'h002);
        chk("ua_fault", 64'(misalign_fault), 64'd0);
        repeat (4) step();
`endif

        // Randomized traffic
        gnt_pct = 60; dly_min = 1; dly_max = 3; fixed_data = 0; stray_en = 1;
        for (int c = 0; c < 3000; c++) begin
            step();
            pc_valid    = ($urandom_range(9, 0) < 7);
            pc_in       = 12'($urandom);
            r           = ($urandom_range(7, 0) != 0);
            if (MIS_EN && r) pc_in[1:0] = 2'b00;
            flush       = ($urandom_range(19, 0) == 0);
            instr_ready = ($urandom_range(9, 0) < 6);
        end
        step(); pc_valid = 1'b0; flush = 1'b0; instr_ready = 1'b1; stray_en = 0;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
